// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU pipeline, the result buffer and its consumer.
// master = ALU producer/consumer side, slave = the buffer.
interface alu_result_buffer_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_result;
    logic              in_carry;
    logic              in_overflow;
    logic              in_zero;
    logic              in_negative;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [3:0]        out_flags;

    modport master (
        output in_valid, in_result, in_carry, in_overflow, in_zero, in_negative, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_result, in_carry, in_overflow, in_zero, in_negative, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/alu_result_buffer.sv
// Small FIFO that buffers ALU results and flags for a stallable consumer, with
// sticky carry/overflow status and a saturating count of refused inputs.
module alu_result_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    alu_result_buffer_if.slave         bus,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       sticky_carry,
    output logic                       sticky_ovf,
    input  logic                       clr_sticky,
    output logic [CNT_W-1:0]           drop_cnt
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int ENT_W = DATA_W + 4;
    localparam logic [PTR_W-1:0] LVL_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] LVL_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       level_q, level_d;
    logic                   sticky_carry_q, sticky_carry_d;
    logic                   sticky_ovf_q, sticky_ovf_d;
    logic [CNT_W-1:0]       drop_cnt_q, drop_cnt_d;
    logic [ENT_W-1:0]       mem_q [DEPTH];
    logic [ENT_W-1:0]       mem_d [DEPTH];
    logic                   push_s, pop_s, refuse_s;
    logic [ENT_W-1:0]       entry_s;
    logic [ENT_W-1:0]       head_s;

    // Handshake is decoded from registered state only; reset blocks acceptance.
    assign bus.in_ready  = (state_q != ST_FULL) & ~rst;
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign push_s   = bus.in_valid & bus.in_ready;
    assign pop_s    = bus.out_valid & bus.out_ready;
    assign refuse_s = bus.in_valid & (state_q == ST_FULL);
    assign entry_s  = {bus.in_carry, bus.in_overflow, bus.in_zero, bus.in_negative, bus.in_result};

    assign head_s         = mem_q[rd_ptr_q[AW-1:0]];
    assign bus.out_result = head_s[DATA_W-1:0];
    assign bus.out_flags  = head_s[ENT_W-1:DATA_W];
    assign level          = level_q;
    assign sticky_carry   = sticky_carry_q;
    assign sticky_ovf     = sticky_ovf_q;
    assign drop_cnt       = drop_cnt_q;

    // Next-state logic: pointers, occupancy, FSM, storage, status.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            mem_d[wr_ptr_q[AW-1:0]] = entry_s;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        // Extra pointer MSB makes the difference span 0..DEPTH.
        level_d = wr_ptr_d - rd_ptr_d;

        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (push_s) state_d = ST_PARTIAL;
                else        state_d = ST_EMPTY;
            end
            ST_PARTIAL: begin
                if (push_s && !pop_s && level_q == LVL_LAST)     state_d = ST_FULL;
                else if (pop_s && !push_s && level_q == LVL_ONE) state_d = ST_EMPTY;
                else                                             state_d = ST_PARTIAL;
            end
            ST_FULL: begin
                if (pop_s) state_d = ST_PARTIAL;
                else       state_d = ST_FULL;
            end
            default: state_d = ST_EMPTY;
        endcase

        // Set wins over a same-cycle clear.
        sticky_carry_d = (sticky_carry_q & ~clr_sticky) | (push_s & bus.in_carry);
        sticky_ovf_d   = (sticky_ovf_q & ~clr_sticky) | (push_s & bus.in_overflow);

        if (refuse_s && drop_cnt_q != CNT_MAX) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_EMPTY;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            level_q        <= '0;
            sticky_carry_q <= 1'b0;
            sticky_ovf_q   <= 1'b0;
            drop_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            level_q        <= level_d;
            sticky_carry_q <= sticky_carry_d;
            sticky_ovf_q   <= sticky_ovf_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    // Entry storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule
